serial_subtractor_ctrl: RTL and testbench
=========================================

// Module: serial_subtractor_ctrl
// PURPOSE
//   Sequences one 1-bit full-subtractor cell (Diff = A^B^Bin, Bout = ~A&B | ~(A^B)&Bin) bit-serially,
//   LSB first, to compute an N-bit D = A - B - Bin. The borrow is held in a register between bits.
//   Operands are accepted through a valid/ready handshake and the result is returned through another.
//   Sits between the operand source and the result consumer. It replaces a WIDTH-cell ripple chain.
// PARAMETERS
//   WIDTH      8    operand/result width in bits; legal range 2..32
//   CNT_W      $clog2(WIDTH)   bit-counter width (derived, not overridden)
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operand request
//   in_ready   out  1      controller can accept operands (high only in IDLE)
//   a          in   WIDTH  minuend, sampled on in_valid&in_ready
//   b          in   WIDTH  subtrahend, sampled on in_valid&in_ready
//   bin        in   1      initial borrow-in, sampled with a/b
//   out_valid  out  1      result available (high only in DONE)
//   out_ready  in   1      consumer accepts result
//   diff       out  WIDTH  difference, stable while out_valid
//   bout       out  1      final borrow-out (1 = A < B+Bin, unsigned)
//   busy       out  1      high in RUN
// BEHAVIOUR
//   - Reset (rst_n low, any time): state=IDLE, in_ready=1, out_valid=0, busy=0, diff=0, bout=0,
//     borrow reg=0, counter=0. Operation in flight is discarded. No partial result is emitted.
//   - FSM IDLE -> RUN on in_valid&in_ready: latch a, b into shift regs and bin into borrow reg; cnt=0.
//   - RUN: one bit per cycle. d_bit = a_sh[0]^b_sh[0]^brw.
//     brw <= (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&brw).
//     d_bit shifts into diff MSB and diff shifts right. a_sh and b_sh shift right. cnt++.
//   - RUN -> DONE after the cycle with cnt==WIDTH-1. Latency is WIDTH+1 clocks from accept to out_valid.
//   - DONE: out_valid=1; diff holds the full result and bout = final brw. Both are stable until the handshake.
//   - DONE -> IDLE on out_valid&out_ready. If out_ready is already high when DONE is entered, there is
//     exactly one DONE cycle.
//   - No new operand is accepted in RUN or DONE; in_valid there is ignored, not queued.
//   - in_ready rises in the cycle after the result handshake. Throughput is 1 op per WIDTH+2 clocks minimum.
//   - Arithmetic is modulo 2^WIDTH: diff = (A - B - Bin) mod 2^WIDTH. bout = borrow out of the MSB.
//   - Operand changes on a/b/bin outside the accept cycle have no effect.
// CONFIGURATION
//   SERIAL_SUB_OVF_EN defined: extra output port `ovf out 1`. It flags signed (two's-complement) overflow:
//     ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the latched operands.
//     It is valid with out_valid, 0 at reset, and held through DONE.
//   SERIAL_SUB_OVF_EN undefined: port ovf absent. The latched MSB copies are removed. Behaviour is otherwise identical.
// TESTING
//   1) WIDTH=8, a=0x5A b=0x23 bin=0, out_ready=1 -> out_valid after 9 clk, diff=0x37, bout=0
//   2) a=0x00 b=0x01 bin=0 -> diff=0xFF, bout=1; a=0x10 b=0x0F bin=1 -> diff=0x00, bout=0
//   3) Exhaustive WIDTH=2: all 32 (a,b,bin) combos vs reference (a-b-bin) mod 4 and borrow; 0 mismatches
//   4) Backpressure: out_ready=0 for 5 clk after out_valid -> diff/bout/out_valid stable;
//      in_valid pulses with a=0xFF in RUN/DONE are ignored; in_ready=0 throughout
//   5) Reset mid-op: deassert rst_n at cnt==3 -> outputs take reset values immediately (async);
//      after release in_ready=1; next op a=0x80 b=0x01 -> diff=0x7F, bout=0
//   6) SERIAL_SUB_OVF_EN: a=0x80 b=0x01 bin=0 -> ovf=1; a=0x7F b=0xFF -> diff=0x80, ovf=1;
//      a=0x05 b=0x03 -> ovf=0

Source files
------------

// File: rtl/serial_subtractor_ctrl.sv
// ---------------------------------------------------------------------------
// serial_subtractor_ctrl
//
// Computes D = A - B - Bin (modulo 2^WIDTH) with a single 1-bit full
// subtractor cell. The cell is stepped one bit per clock, LSB first. The
// borrow is kept in a register between bits, so this block stands in for a
// WIDTH-cell ripple chain. Operands arrive through a valid/ready handshake
// and the result leaves through a second valid/ready handshake.
//
// Timing: the result appears WIDTH+1 clocks after the operand handshake.
// At most one operation is in flight. Operand requests made while busy or
// while a result is pending are ignored; they are not queued.
//
// Parameters
//   WIDTH      operand/result width, 2..32
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand request
//   in_ready   out  operands can be accepted (IDLE only)
//   a, b       in   minuend / subtrahend, sampled on in_valid & in_ready
//   bin        in   initial borrow-in, sampled with a/b
//   out_valid  out  result available (DONE only)
//   out_ready  in   consumer accepts the result
//   diff       out  difference, stable while out_valid
//   bout       out  borrow out of the MSB (1 = A < B + Bin, unsigned)
//   busy       out  high while bits are being processed
//   ovf        out  signed overflow flag (only when SERIAL_SUB_OVF_EN defined)
//
// Build option
//   SERIAL_SUB_OVF_EN : adds the ovf output and the latched operand MSBs.
// ---------------------------------------------------------------------------
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Full-subtractor cell: difference bit.
  function automatic logic sub_diff(input logic a_i, input logic b_i, input logic bw_i);
    return a_i ^ b_i ^ bw_i;
  endfunction

  // Full-subtractor cell: borrow out.
  function automatic logic sub_borrow(input logic a_i, input logic b_i, input logic bw_i);
    return (~a_i & b_i) | (~(a_i ^ b_i) & bw_i);
  endfunction

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               brw_q, brw_d;
  logic               bout_q, bout_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               d_bit_s;
  logic               brw_next_s;
`ifdef SERIAL_SUB_OVF_EN
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic               ovf_q, ovf_d;
`endif

  // Next-state, datapath and output computation.
  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    diff_d      = diff_q;
    cnt_d       = cnt_q;
    brw_d       = brw_q;
    bout_d      = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    ovf_d       = ovf_q;
`endif
    d_bit_s     = sub_diff(a_sh_q[0], b_sh_q[0], brw_q);
    brw_next_s  = sub_borrow(a_sh_q[0], b_sh_q[0], brw_q);

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d = ST_RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          brw_d   = bin;
          cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        // The new difference bit enters at the MSB; after WIDTH shifts the
        // first (LSB) bit has reached diff[0].
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        diff_d = {d_bit_s, diff_q[WIDTH-1:1]};
        brw_d  = brw_next_s;
        if (cnt_q == LAST_BIT) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          bout_d  = brw_next_s;
`ifdef SERIAL_SUB_OVF_EN
          // d_bit_s on the last step is the result MSB.
          ovf_d   = (a_msb_q != b_msb_q) && (d_bit_s != a_msb_q);
`endif
        end else begin
          state_d = ST_RUN;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Handshake flags are registered copies of the next state.
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d == ST_RUN);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      diff_q      <= '0;
      cnt_q       <= '0;
      brw_q       <= 1'b0;
      bout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      diff_q      <= diff_d;
      cnt_q       <= cnt_d;
      brw_q       <= brw_d;
      bout_q      <= bout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor_ctrl
//
// Self-checking bench for serial_subtractor_ctrl. It uses a WIDTH=8
// instance for the main scenarios and a WIDTH=2 instance for the
// exhaustive sweep. Expected results come from plain integer arithmetic:
// diff = (a - b - bin) mod 2^W, and bout = (a - b - bin) < 0.
// ---------------------------------------------------------------------------
module tb_serial_subtractor_ctrl;

  logic       clk;
  logic       rst_n;

  logic       in_valid, in_ready, bin, out_valid, out_ready, bout, busy;
  logic [7:0] a, b, diff;
  logic       ovf_s;

  logic       w2_in_valid, w2_in_ready, w2_bin, w2_out_valid, w2_out_ready, w2_bout, w2_busy;
  logic [1:0] w2_a, w2_b, w2_diff;
`ifdef SERIAL_SUB_OVF_EN
  logic       w2_ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_subtractor_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .busy(busy)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf_s)
`endif
  );

  serial_subtractor_ctrl #(.WIDTH(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(w2_in_valid), .in_ready(w2_in_ready),
    .a(w2_a), .b(w2_b), .bin(w2_bin),
    .out_valid(w2_out_valid), .out_ready(w2_out_ready),
    .diff(w2_diff), .bout(w2_bout), .busy(w2_busy)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(w2_ovf)
`endif
  );

`ifndef SERIAL_SUB_OVF_EN
  assign ovf_s = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: unsigned subtraction with borrow.
  function automatic logic [7:0] ref_diff(input logic [7:0] ai, input logic [7:0] bi, input logic bi_n);
    int x;
    x = int'(ai) - int'(bi) - int'(bi_n);
    return x[7:0];
  endfunction

  function automatic logic ref_bout(input logic [7:0] ai, input logic [7:0] bi, input logic bi_n);
    return (int'(ai) - int'(bi) - int'(bi_n)) < 0;
  endfunction

  // Drives one operation into the WIDTH=8 instance and returns observations.
  // The consumer stalls for `hold` cycles after out_valid rises. Operands are
  // scrambled right after the accept cycle so that late changes would show up.
  task automatic drive_op8(input logic [7:0] ai, input logic [7:0] bi, input logic bi_n,
                           input int hold, output int lat, output logic [7:0] d_o,
                           output logic bo_o, output logic ov_o, output bit stable_o);
    @(negedge clk);
    a = ai; b = bi; bin = bi_n; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    d_o = diff; bo_o = bout; ov_o = ovf_s; stable_o = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (diff !== d_o || bout !== bo_o || out_valid !== 1'b1 || in_ready !== 1'b0) stable_o = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b0; a = 8'h00; b = 8'h00; bin = 1'b0; out_ready = 1'b1;
    w2_in_valid = 1'b0; w2_a = 2'd0; w2_b = 2'd0; w2_bin = 1'b0; w2_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, bout, ovf_s} !== 5'b10000 || diff !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b vld=%b busy=%b bout=%b ovf=%b diff=%h, want 1 0 0 0 0 00",
               in_ready, out_valid, busy, bout, ovf_s, diff);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b vld=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed;
    logic [7:0] av [3] = '{8'h5A, 8'h00, 8'h10};
    logic [7:0] bv [3] = '{8'h23, 8'h01, 8'h0F};
    logic       cv [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] ed [3] = '{8'h37, 8'hFF, 8'h00};
    logic       eb [3] = '{1'b0, 1'b1, 1'b0};
    int lat; logic [7:0] d; logic bo, ov; bit st;
    for (int i = 0; i < 3; i++) begin
      drive_op8(av[i], bv[i], cv[i], 0, lat, d, bo, ov, st);
      checks++;
      if (lat !== 9) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d clocks, want 9", i, lat);
      end
      checks++;
      if (d !== ed[i] || bo !== eb[i]) begin
        errors++;
        $display("FAIL directed_result[%0d]: got diff=%h bout=%b, want diff=%h bout=%b", i, d, bo, ed[i], eb[i]);
      end
      // With out_ready already high there is exactly one DONE cycle.
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL directed_single_done[%0d]: got rdy=%b vld=%b, want 1 0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_exhaustive_w2;
    int n_bad = 0;
    for (int ai = 0; ai < 4; ai++) begin
      for (int bi = 0; bi < 4; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          int x, lat;
          logic [1:0] ed;
          logic eb;
          x  = ai - bi - ci;
          ed = x[1:0];
          eb = (x < 0);
          @(negedge clk);
          w2_a = 2'(ai); w2_b = 2'(bi); w2_bin = 1'(ci); w2_in_valid = 1'b1; w2_out_ready = 1'b1;
          @(negedge clk);
          w2_in_valid = 1'b0;
          lat = 1;
          while (!w2_out_valid && lat < 32) begin
            @(negedge clk);
            lat++;
          end
          checks++;
          if (lat !== 3 || w2_diff !== ed || w2_bout !== eb) begin
            errors++;
            n_bad++;
            $display("FAIL w2_exhaustive a=%0d b=%0d bin=%0d: got diff=%0d bout=%b lat=%0d, want diff=%0d bout=%b lat=3",
                     ai, bi, ci, w2_diff, w2_bout, lat, ed, eb);
          end
          @(negedge clk);
        end
      end
    end
    $display("w2 exhaustive sweep: %0d of 32 combinations disagreed", n_bad);
  endtask

  task automatic test_backpressure;
    logic [7:0] d0; logic b0;
    bit rdy_bad = 1'b0, busy_bad = 1'b0, hold_bad = 1'b0;
    int lat = 1;
    @(negedge clk);
    a = 8'h5A; b = 8'h23; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    // Ignored requests during RUN: alternating in_valid pulses with a=FF.
    while (!out_valid && lat < 64) begin
      in_valid = lat[0]; a = 8'hFF; b = 8'h00;
      if (in_ready !== 1'b0) rdy_bad = 1'b1;
      if (busy !== 1'b1) busy_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    d0 = diff; b0 = bout;
    checks++;
    if (lat !== 9 || d0 !== 8'h37 || b0 !== 1'b0) begin
      errors++;
      $display("FAIL bp_result: got diff=%h bout=%b lat=%0d, want 37 0 9", d0, b0, lat);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      @(negedge clk);
      if (diff !== d0 || bout !== b0 || out_valid !== 1'b1) hold_bad = 1'b1;
      if (in_ready !== 1'b0) rdy_bad = 1'b1;
    end
    checks++;
    if (hold_bad) begin
      errors++;
      $display("FAIL bp_hold: got diff=%h bout=%b vld=%b after stall, want 37 0 1", diff, bout, out_valid);
    end
    checks++;
    if (rdy_bad || busy_bad) begin
      errors++;
      $display("FAIL bp_ready_busy: got in_ready_seen_high=%b busy_seen_low=%b, want 0 0", rdy_bad, busy_bad);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    // No queued request may have started a second operation.
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_queue: got rdy=%b vld=%b busy=%b, want 1 0 0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_reset_mid_op;
    int lat; logic [7:0] d; logic bo, ov; bit st;
    @(negedge clk);
    a = 8'h5A; b = 8'h23; bin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, bout, ovf_s} !== 5'b10000 || diff !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_async: got rdy=%b vld=%b busy=%b bout=%b ovf=%b diff=%h, want 1 0 0 0 0 00",
               in_ready, out_valid, busy, bout, ovf_s, diff);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL mid_reset_no_partial: got vld=%b rdy=%b, want 0 1", out_valid, in_ready);
      end
    end
    drive_op8(8'h80, 8'h01, 1'b0, 0, lat, d, bo, ov, st);
    checks++;
    if (lat !== 9 || d !== 8'h7F || bo !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_next_op: got diff=%h bout=%b lat=%0d, want 7f 0 9", d, bo, lat);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 30; i++) begin
      logic [7:0] ai, bi, d;
      logic ci, bo, ov;
      int lat, hold;
      bit st;
      ai = 8'($urandom); bi = 8'($urandom); ci = 1'($urandom);
      hold = $urandom_range(0, 3);
      drive_op8(ai, bi, ci, hold, lat, d, bo, ov, st);
      checks++;
      if (lat !== 9 || d !== ref_diff(ai, bi, ci) || bo !== ref_bout(ai, bi, ci) || !st) begin
        errors++;
        $display("FAIL random[%0d] a=%h b=%h bin=%b hold=%0d: got diff=%h bout=%b lat=%0d stable=%b, want diff=%h bout=%b lat=9 stable=1",
                 i, ai, bi, ci, hold, d, bo, lat, st, ref_diff(ai, bi, ci), ref_bout(ai, bi, ci));
      end
`ifdef SERIAL_SUB_OVF_EN
      begin
        logic [7:0] rd;
        logic eo;
        rd = ref_diff(ai, bi, ci);
        eo = (ai[7] != bi[7]) && (rd[7] != ai[7]);
        checks++;
        if (ov !== eo) begin
          errors++;
          $display("FAIL random_ovf[%0d] a=%h b=%h bin=%b: got ovf=%b, want %b", i, ai, bi, ci, ov, eo);
        end
      end
`endif
    end
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf;
    logic [7:0] av [3] = '{8'h80, 8'h7F, 8'h05};
    logic [7:0] bv [3] = '{8'h01, 8'hFF, 8'h03};
    logic [7:0] ed [3] = '{8'h7F, 8'h80, 8'h02};
    logic       eo [3] = '{1'b1, 1'b1, 1'b0};
    int lat; logic [7:0] d; logic bo, ov; bit st;
    for (int i = 0; i < 3; i++) begin
      drive_op8(av[i], bv[i], 1'b0, 2, lat, d, bo, ov, st);
      checks++;
      if (d !== ed[i] || ov !== eo[i]) begin
        errors++;
        $display("FAIL ovf_directed[%0d]: got diff=%h ovf=%b, want diff=%h ovf=%b", i, d, ov, ed[i], eo[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_exhaustive_w2();
    test_backpressure();
    test_reset_mid_op();
    test_random();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
